// File: rtl/shift_pipe_pkg.sv
// -----------------------------------------------------------------------------
// shift_pipe_pkg
// Shared definitions for the shift_pipe_ctrl block:
//   - state_e     : controller FSM encoding (IDLE, RUN, DRAIN, FLUSH)
//   - STAT_MAX    : saturation value of the optional statistics counters
//   - sat_inc32() : saturating 32-bit increment helper
// -----------------------------------------------------------------------------
package shift_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_e;

    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == STAT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/shift_pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_pipe_ctrl_if
// Valid/ready streaming channel used on both sides of shift_pipe_ctrl.
//   valid : sender has a word on data
//   ready : receiver takes the word this cycle
//   data  : DW-bit payload
// Modports:
//   master : drives valid/data, observes ready (sender side)
//   slave  : observes valid/data, drives ready (receiver side)
// -----------------------------------------------------------------------------
interface shift_pipe_ctrl_if #(
    parameter int DW = 1
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/shift_pipe_stage.sv
// -----------------------------------------------------------------------------
// shift_pipe_stage
// One stage of the shift/delay datapath: a DW-bit data register plus a valid
// bit.
// Ports:
//   clk        : clock, all state on posedge
//   rst        : synchronous active-high reset (clears data and valid)
//   en         : global advance; stage loads the previous stage
//   clr        : flush; clears the valid bit only, data is left alone
//   prev_data  : data of the upstream stage (or the input word for stage 0)
//   prev_valid : valid of the upstream stage (or the accept strobe)
//   data       : registered stage data
//   valid      : registered stage valid
// -----------------------------------------------------------------------------
module shift_pipe_stage #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [DW-1:0] prev_data,
    input  logic          prev_valid,
    output logic [DW-1:0] data,
    output logic          valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data registers are reset as well as the valids, so a
            // reset leaves no stale word visible on the output.
            data  <= '0;
            valid <= 1'b0;
        end else begin
            if (en) begin
                data <= prev_data;
            end
            // Flush wins over the shift for the valid bit; data may still move.
            if (clr) begin
                valid <= 1'b0;
            end else if (en) begin
                valid <= prev_valid;
            end
        end
    end

endmodule

// File: rtl/shift_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// shift_pipe_ctrl
// Controller/sequencer for a DEPTH-stage global-stall shift pipeline with
// per-stage valid tracking, valid/ready backpressure, drain and flush.
// Ports:
//   clk        : clock, all logic on posedge
//   rst        : synchronous active-high reset
//   up         : input stream (slave modport: valid/data in, ready out)
//   down       : output stream (master modport: valid/data out, ready in)
//   drain_req  : stop accepting input and let the pipe empty
//   flush      : discard every in-flight word
//   busy       : controller is not IDLE
//   occupancy  : number of valid stages
//   sent_cnt   : (SHIFT_PIPE_CTRL_STATS_EN only) delivered-word count, saturating
//   stall_cnt  : (SHIFT_PIPE_CTRL_STATS_EN only) stalled-output cycles, saturating
// Build option: define SHIFT_PIPE_CTRL_STATS_EN to add the statistics counters.
// -----------------------------------------------------------------------------
module shift_pipe_ctrl
    import shift_pipe_pkg::*;
#(
    parameter int DW    = 1,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_pipe_ctrl_if.slave     up,
    shift_pipe_ctrl_if.master    down,
    input  logic                 drain_req,
    input  logic                 flush,
    output logic                 busy,
    output logic [CNT_W-1:0]     occupancy
`ifdef SHIFT_PIPE_CTRL_STATS_EN
    ,
    output logic [31:0]          sent_cnt,
    output logic [31:0]          stall_cnt
`endif
);

    state_e state;
    state_e state_next;

    logic [CNT_W-1:0] occ_next;
    logic             adv;
    logic             in_ready;
    logic             accept;
    logic             deliver;
    logic             out_valid;

    // Index 0 is the pipe input; index k+1 is the output of stage k.
    logic [DEPTH:0][DW-1:0] chain_data;
    logic [DEPTH:0]         chain_valid;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign out_valid = chain_valid[DEPTH];
    // Single global stall: the whole pipe moves only if the last stage is
    // empty or being consumed.
    assign adv       = !out_valid || down.ready;
    // drain_req outranks a normal accept, so it gates in_ready directly
    // rather than waiting for the FSM to reach DRAIN.
    assign in_ready  = !rst && adv && ((state == IDLE) || (state == RUN))
                       && !flush && !drain_req;
    assign accept    = up.valid && in_ready;
    assign deliver   = out_valid && down.ready;

    assign up.ready   = in_ready;
    assign down.valid = out_valid;
    assign down.data  = chain_data[DEPTH];
    assign busy       = (state != IDLE);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign chain_data[0]  = up.data;
    assign chain_valid[0] = accept;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        shift_pipe_stage #(.DW(DW)) u_stage (
            .clk        (clk),
            .rst        (rst),
            .en         (adv),
            .clr        (flush),
            .prev_data  (chain_data[k]),
            .prev_valid (chain_valid[k]),
            .data       (chain_data[k+1]),
            .valid      (chain_valid[k+1])
        );
    end

    // ------------------------------------------------------------------
    // Occupancy
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch
        // is inferred on paths that do not assign it.
        occ_next = occupancy;
        if (flush) begin
            occ_next = '0;
        end else if (accept && !deliver) begin
            if (occupancy != CNT_W'(DEPTH)) occ_next = occupancy + 1'b1;
        end else if (deliver && !accept) begin
            if (occupancy != '0) occ_next = occupancy - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values.
            occupancy <= occ_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = FLUSH;
        end else begin
            unique case (state)
                IDLE: begin
                    if (drain_req)   state_next = DRAIN;
                    else if (accept) state_next = RUN;
                end
                RUN: begin
                    if (drain_req)           state_next = DRAIN;
                    else if (occ_next == '0) state_next = IDLE;
                end
                DRAIN: begin
                    // Held here while drain_req stays high, even when empty.
                    if (!drain_req && (occ_next == '0)) state_next = IDLE;
                end
                FLUSH: begin
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef SHIFT_PIPE_CTRL_STATS_EN
    // A delivery in a flush cycle still counts; flush never clears these.
    always_ff @(posedge clk) begin
        if (rst) begin
            sent_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (deliver)                  sent_cnt  <= sat_inc32(sent_cnt);
            if (out_valid && !down.ready) stall_cnt <= sat_inc32(stall_cnt);
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_shift_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_pipe_ctrl
// Self-checking bench for shift_pipe_ctrl (DW=1, DEPTH=3). Accepted words are
// pushed to a scoreboard queue and popped/compared when the DUT delivers them;
// occupancy is tracked by an independent counter model.
// -----------------------------------------------------------------------------
module tb_shift_pipe_ctrl;

    localparam int DW    = 1;
    localparam int DEPTH = 3;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             drain_req;
    logic             flush;
    logic             busy;
    logic [CNT_W-1:0] occupancy;
`ifdef SHIFT_PIPE_CTRL_STATS_EN
    logic [31:0]      sent_cnt;
    logic [31:0]      stall_cnt;
`endif

    shift_pipe_ctrl_if #(.DW(DW)) up_if ();
    shift_pipe_ctrl_if #(.DW(DW)) down_if ();

    shift_pipe_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .up        (up_if.slave),
        .down      (down_if.master),
        .drain_req (drain_req),
        .flush     (flush),
        .busy      (busy),
        .occupancy (occupancy)
`ifdef SHIFT_PIPE_CTRL_STATS_EN
        ,
        .sent_cnt  (sent_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] sb_q[$];
    int            model_occ = 0;
    int            delivered = 0;

    logic             s_in_ready;
    logic             s_out_valid;
    logic [DW-1:0]    s_out_data;
    logic [CNT_W-1:0] s_occ;
    logic             s_busy;

    // One clock cycle: entered just after a negedge with inputs already
    // driven. Samples outputs, updates the scoreboard, then crosses posedge.
    task automatic cycle();
        logic acc;
        logic del;
        logic [DW-1:0] exp_word;
        #1;
        s_in_ready  = up_if.ready;
        s_out_valid = down_if.valid;
        s_out_data  = down_if.data;
        s_occ       = occupancy;
        s_busy      = busy;
        acc = up_if.valid && up_if.ready;
        del = down_if.valid && down_if.ready;
        if (!rst) begin
            total++;
            if (occupancy !== CNT_W'(model_occ)) begin
                bad++;
                $display("FAIL occupancy: got %0d want %0d", occupancy, model_occ);
            end
            if (del) begin
                total++;
                delivered++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output: got data %0h want no output", down_if.data);
                end else begin
                    exp_word = sb_q.pop_front();
                    if (down_if.data !== exp_word) begin
                        bad++;
                        $display("FAIL out_data: got %0h want %0h", down_if.data, exp_word);
                    end
                end
            end
            if (acc) sb_q.push_back(up_if.data);
        end
        if (rst || flush) begin
            sb_q.delete();
            model_occ = 0;
        end else begin
            model_occ = model_occ + int'(acc) - int'(del);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_bit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", name, got, want);
        end
    endtask

    // Empty the pipe with the consumer always ready; bounded.
    task automatic drain_out(input string name);
        up_if.valid    = 1'b0;
        down_if.ready  = 1'b1;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            if (sb_q.size() == 0 && occupancy == '0) break;
            cycle();
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d words left want 0", name, sb_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; up_if.valid = 1'b0; up_if.data = '0;
        down_if.ready = 1'b1; drain_req = 1'b0; flush = 1'b0;
        cycle();
        cycle();
        expect_bit("reset_out_valid", s_out_valid, 1'b0);
        expect_bit("reset_busy", s_busy, 1'b0);
        expect_bit("reset_in_ready", s_in_ready, 1'b0);
        expect_bit("reset_out_data", s_out_data[0], 1'b0);
        total++;
        if (s_occ !== '0) begin
            bad++;
            $display("FAIL reset_occupancy: got %0d want 0", s_occ);
        end
        rst = 1'b0;
        cycle();
        expect_bit("post_reset_in_ready", s_in_ready, 1'b1);
    endtask

    task automatic test_latency();
        logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int peak = 0;
        down_if.ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            up_if.valid = (c < 4);
            up_if.data  = (c < 4) ? pat[c] : 1'b0;
            cycle();
            if (int'(s_occ) > peak) peak = int'(s_occ);
            expect_bit($sformatf("latency_out_valid_c%0d", c), s_out_valid, (c >= 3 && c <= 6));
            if (c < 4) expect_bit($sformatf("latency_in_ready_c%0d", c), s_in_ready, 1'b1);
        end
        total++;
        if (peak != 3) begin
            bad++;
            $display("FAIL latency_peak_occ: got %0d want 3", peak);
        end
        expect_bit("latency_idle_busy", s_busy, 1'b0);
    endtask

    task automatic test_stall();
`ifdef SHIFT_PIPE_CTRL_STATS_EN
        logic [31:0] stall0;
`endif
        up_if.valid = 1'b1; down_if.ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            up_if.data = DW'(c & 1);
            cycle();
        end
`ifdef SHIFT_PIPE_CTRL_STATS_EN
        stall0 = stall_cnt;
`endif
        up_if.data = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            expect_bit("stall_in_ready", s_in_ready, 1'b0);
            expect_bit("stall_out_valid", s_out_valid, 1'b1);
            total++;
            if (sb_q.size() == 0 || s_out_data !== sb_q[0]) begin
                bad++;
                $display("FAIL stall_hold: got %0h want head word (queue size %0d)", s_out_data, sb_q.size());
            end
        end
`ifdef SHIFT_PIPE_CTRL_STATS_EN
        total++;
        if (stall_cnt - stall0 != 32'd5) begin
            bad++;
            $display("FAIL stall_cnt: got %0d want 5", stall_cnt - stall0);
        end
`endif
        drain_out("stall");
    endtask

    task automatic test_flush();
        up_if.valid = 1'b1; down_if.ready = 1'b1; up_if.data = 1'b1;
        cycle();
        up_if.data = 1'b0;
        cycle();
        flush = 1'b1; up_if.data = 1'b1;
        cycle();
        expect_bit("flush_in_ready", s_in_ready, 1'b0);
        flush = 1'b0; up_if.valid = 1'b0;
        cycle();
        expect_bit("flush_busy", s_busy, 1'b1);
        expect_bit("flush_out_valid", s_out_valid, 1'b0);
        expect_bit("flush_in_ready_after", s_in_ready, 1'b0);
        total++;
        if (s_occ !== '0) begin
            bad++;
            $display("FAIL flush_occupancy: got %0d want 0", s_occ);
        end
        cycle();
        expect_bit("flush_idle_busy", s_busy, 1'b0);
        expect_bit("flush_idle_in_ready", s_in_ready, 1'b1);
        for (int c = 0; c < 5; c++) begin
            cycle();
            expect_bit("flush_no_output", s_out_valid, 1'b0);
        end
    endtask

    task automatic test_drain();
        up_if.valid = 1'b1; down_if.ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            up_if.data = DW'(~c & 1);
            cycle();
        end
        drain_req = 1'b1; down_if.ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cycle();
            expect_bit("drain_in_ready", s_in_ready, 1'b0);
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain_words_left: got %0d want 0", sb_q.size());
        end
        expect_bit("drain_held_busy", s_busy, 1'b1);
        drain_req = 1'b0; up_if.valid = 1'b0;
        cycle();
        expect_bit("drain_release_busy_same", s_busy, 1'b1);
        cycle();
        expect_bit("drain_release_idle", s_busy, 1'b0);
    endtask

    task automatic test_reset_mid();
        up_if.valid = 1'b1; down_if.ready = 1'b1; up_if.data = 1'b1;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        cycle();
        expect_bit("midrst_out_valid", s_out_valid, 1'b0);
        expect_bit("midrst_busy", s_busy, 1'b0);
        expect_bit("midrst_in_ready", s_in_ready, 1'b0);
        expect_bit("midrst_out_data", s_out_data[0], 1'b0);
        total++;
        if (s_occ !== '0) begin
            bad++;
            $display("FAIL midrst_occupancy: got %0d want 0", s_occ);
        end
`ifdef SHIFT_PIPE_CTRL_STATS_EN
        total++;
        if (sent_cnt !== 32'd0) begin
            bad++;
            $display("FAIL midrst_sent_cnt: got %0d want 0", sent_cnt);
        end
`endif
        rst = 1'b0; up_if.valid = 1'b0;
        cycle();
    endtask

    task automatic test_back_to_back();
        int base = delivered;
        up_if.valid = 1'b1; down_if.ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            up_if.data = DW'($urandom_range(1, 0));
            cycle();
            if (c >= 3) begin
                total++;
                if (s_occ !== CNT_W'(3)) begin
                    bad++;
                    $display("FAIL b2b_occupancy_c%0d: got %0d want 3", c, s_occ);
                end
            end
        end
        drain_out("b2b");
        total++;
        if (delivered - base != 100) begin
            bad++;
            $display("FAIL b2b_delivered: got %0d want 100", delivered - base);
        end
`ifdef SHIFT_PIPE_CTRL_STATS_EN
        total++;
        if (sent_cnt !== 32'd100) begin
            bad++;
            $display("FAIL b2b_sent_cnt: got %0d want 100", sent_cnt);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; up_if.valid = 1'b0; up_if.data = '0;
        down_if.ready = 1'b1; drain_req = 1'b0; flush = 1'b0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_stall();
        test_flush();
        test_drain();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion want finish before 200000");
        $fatal(1, "simulation timeout");
    end

endmodule
